// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader boot stage.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    PAYLOAD = 3'd3,
    CHK     = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles without a clear, flags when the limit is reached.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          w_expired;

  // Fires on the edge that would complete the TIMEOUT_CYCLES-th idle cycle.
  assign w_expired = i_en && !i_clr && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign o_expired = w_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (!w_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a framed byte stream, writes 32-bit words into instruction
// memory and releases the core from reset once the frame checksum matches.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output loader_state_t         dbg_state
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Link handshake: a byte transfers on any cycle with in_valid high, since
  // in_ready is constantly 1 and the loader never applies backpressure.
  loader_state_t         r_state;
  logic [7:0]            r_len_lo;
  logic [ADDR_WIDTH:0]   r_len;
  logic [1:0]            r_byte_idx;
  logic [ADDR_WIDTH:0]   r_word_idx;
  logic [23:0]           r_word;
  logic [7:0]            r_checksum;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_core_reset;
  logic                  r_load_done;
  logic                  r_load_error;
  logic [ADDR_WIDTH:0]   r_words_loaded;

  logic [15:0]           w_len;
  logic [ADDR_WIDTH:0]   w_word_next;
  logic                  w_timer_en;
  logic                  w_expired;

  assign w_len       = {in_data, r_len_lo};
  assign w_word_next = r_word_idx + 1'b1;
  assign w_timer_en  = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                       (r_state == PAYLOAD) || (r_state == CHK);

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (in_valid),
    .i_en      (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_len_lo       <= '0;
      r_len          <= '0;
      r_byte_idx     <= '0;
      r_word_idx     <= '0;
      r_word         <= '0;
      r_checksum     <= '0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_core_reset   <= 1'b1;
      r_load_done    <= 1'b0;
      r_load_error   <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_expired) begin
        r_state      <= ERROR;
        r_load_error <= 1'b1;
        r_core_reset <= 1'b1;
      end else if (in_valid) begin
        case (r_state)
          IDLE: if (in_data == SYNC_BYTE) r_state <= LEN_LO;
          LEN_LO: begin
            r_len_lo <= in_data;
            r_state  <= LEN_HI;
          end
          LEN_HI: begin
            if (w_len == 16'd0 || w_len > 16'(DEPTH)) begin
              r_state      <= ERROR;
              r_load_error <= 1'b1;
            end else begin
              r_len      <= w_len[ADDR_WIDTH:0];
              r_byte_idx <= '0;
              r_word_idx <= '0;
              r_checksum <= '0;
              r_state    <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            r_checksum <= r_checksum ^ in_data;
            r_byte_idx <= r_byte_idx + 1'b1;
            case (r_byte_idx)
              2'd0: r_word[7:0]   <= in_data;
              2'd1: r_word[15:8]  <= in_data;
              2'd2: r_word[23:16] <= in_data;
              default: begin
                // Strobe registers here so it overlaps capture of the next byte.
                r_we           <= 1'b1;
                r_addr         <= r_word_idx[ADDR_WIDTH-1:0];
                r_wdata        <= {in_data, r_word};
                r_words_loaded <= w_word_next;
                r_word_idx     <= w_word_next;
                if (w_word_next == r_len) r_state <= CHK;
              end
            endcase
          end
          CHK: begin
            if (in_data == r_checksum) begin
              r_state      <= DONE;
              r_core_reset <= 1'b0;
              r_load_done  <= 1'b1;
            end else begin
              r_state      <= ERROR;
              r_load_error <= 1'b1;
            end
          end
          DONE, ERROR: begin
            if (in_data == SYNC_BYTE) begin
              r_state        <= LEN_LO;
              r_core_reset   <= 1'b1;
              r_load_done    <= 1'b0;
              r_load_error   <= 1'b0;
              r_words_loaded <= '0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign in_ready     = 1'b1;
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign core_reset   = r_core_reset;
  assign load_done    = r_load_done;
  assign load_error   = r_load_error;
  assign words_loaded = r_words_loaded;
  assign dbg_state    = r_state;

endmodule
